restoring_divider_16by8: RTL



---
 rtl/divider_pkg.sv | 18 +
 rtl/restoring_divider_16by8_div_step.sv | 35 +++
 rtl/restoring_divider_16by8.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents: FSM state encoding, default operand widths and the
// quotient value reported on divide-by-zero.
package divider_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned VW_DEFAULT = 8;

    // Quotient reported when the divisor is zero (all ones).
    localparam logic [DW_DEFAULT-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_16by8_div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem      - current partial remainder (always < divisor)
//   bit_in   - next dividend bit shifted into the remainder
//   divisor  - denominator
//   rem_next - updated partial remainder
//   q_bit    - quotient bit produced by this iteration
module div_step #(
    parameter int unsigned VW = 8
) (
    input  logic [VW-1:0] rem,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_next,
    output logic          q_bit
);

    // One extra bit so the shifted remainder never overflows the compare.
    logic [VW:0] pr;
    logic [VW:0] diff;

    always_comb begin
        pr   = {rem, bit_in};
        diff = pr - {1'b0, divisor};
        if (pr >= {1'b0, divisor}) begin
            // Difference is below the divisor, so it fits in VW bits.
            rem_next = diff[VW-1:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = pr[VW-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/restoring_divider_16by8.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - input handshake (ready only in IDLE)
//   dividend, divisor   - unsigned operands, sampled on the accept edge
//   out_valid, out_ready- output handshake; results held until taken
//   quotient, remainder - unsigned result
//   div_by_zero         - result came from a zero divisor
module restoring_divider_16by8
    import divider_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW + 1);

    state_t        state;
    state_t        next_state;

    logic [DW-1:0] q_work;
    logic [VW-1:0] rem_work;
    logic [VW-1:0] divisor_hold;
    logic [CW-1:0] count;

    logic [VW-1:0] rem_next;
    logic          q_bit;

    logic          accept;
    logic          step;
    logic          last_step;
    logic          release_result;
    logic          zero_divisor;

    div_step #(.VW(VW)) u_step (
        .rem      (rem_work),
        .bit_in   (q_work[DW-1]),
        .divisor  (divisor_hold),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        accept         = 1'b0;
        step           = 1'b0;
        last_step      = 1'b0;
        release_result = 1'b0;
        zero_divisor   = (divisor == '0);
        unique case (state)
            IDLE:    accept         = in_valid && in_ready;
            CALC: begin
                step      = 1'b1;
                last_step = (count == CW'(1));
            end
            DONE:    release_result = out_valid && out_ready;
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
            q_work       <= '0;
            rem_work     <= '0;
            divisor_hold <= '0;
            count        <= '0;
        end else begin
            in_ready <= (next_state == IDLE);
            if (accept) begin
                q_work       <= dividend;
                rem_work     <= '0;
                divisor_hold <= divisor;
                count        <= CW'(DW);
                div_by_zero  <= 1'b0;
                if (zero_divisor) begin
                    // No iterations needed: publish the fixed zero-divisor result.
                    quotient    <= DW'(DBZ_QUOTIENT);
                    remainder   <= dividend[VW-1:0];
                    div_by_zero <= 1'b1;
                    out_valid   <= 1'b1;
                end
            end else if (step) begin
                q_work   <= {q_work[DW-2:0], q_bit};
                rem_work <= rem_next;
                count    <= count - CW'(1);
                if (last_step) begin
                    quotient  <= {q_work[DW-2:0], q_bit};
                    remainder <= rem_next;
                    out_valid <= 1'b1;
                end
            end else if (release_result) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
